// File: rtl/timing_capture_writer.sv
// timing_capture_writer
//   Samples a field vector every clock. It emits one timestamped record for each change, for a
//   write strobe, for the first RUN cycle and when the timestamp wraps to zero. Records are
//   buffered in a first-word-fall-through FIFO and streamed out on a valid/ready interface.
// Ports
//   clk_i        system clock
//   reset_i      asynchronous active-high reset
//   enable_i     level, high = capture running
//   fields_i     field vector sampled every clock
//   wstb_i       force a record this cycle
//   rec_valid_o  record available on rec_ts_o / rec_data_o
//   rec_ready_i  consumer accepts the record when valid & ready
//   rec_ts_o     record timestamp (clock ticks since capture start)
//   rec_data_o   record field values
//   overflow_o   sticky, a record was lost to a full FIFO
//   active_o     high while in RUN
module timing_capture_writer #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned TS_W       = 32,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              enable_i,
  input  logic [DATA_W-1:0] fields_i,
  input  logic              wstb_i,
  output logic              rec_valid_o,
  input  logic              rec_ready_i,
  output logic [TS_W-1:0]   rec_ts_o,
  output logic [DATA_W-1:0] rec_data_o,
  output logic              overflow_o,
  output logic              active_o
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StRun, StHalt} state_e;

  state_e              state_q, state_d;
  logic [TS_W-1:0]     ts_q, ts_d;          // timestamp of the next sample while in RUN
  logic [DATA_W-1:0]   prev_q, prev_d;
  logic                pend_q, pend_d;      // record sampled last edge, written this edge
  logic [TS_W-1:0]     pend_ts_q, pend_ts_d;
  logic [DATA_W-1:0]   pend_data_q, pend_data_d;
  logic                ovf_q, ovf_d;
  logic                active_q, active_d;
  logic [AW:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;

  logic [TS_W-1:0]     mem_ts   [FIFO_DEPTH];
  logic [DATA_W-1:0]   mem_data [FIFO_DEPTH];

  logic [AW:0] count;
  logic        empty, full, pop, push_req, push, ovf_event;

  always_comb begin
    count     = wr_ptr_q - rd_ptr_q;
    empty     = (count == '0);
    full      = (count == (AW+1)'(FIFO_DEPTH));
    pop       = !empty && rec_ready_i;
    // A pending record is only written while capture is still running; disabling drops it.
    push_req  = pend_q && (state_q == StRun) && enable_i;
    push      = push_req && (!full || pop);
    ovf_event = push_req && full && !pop;
  end

  always_comb begin
    state_d     = state_q;
    ts_d        = ts_q;
    prev_d      = fields_i;
    pend_d      = 1'b0;
    pend_ts_d   = pend_ts_q;
    pend_data_d = pend_data_q;
    ovf_d       = ovf_q;
    unique case (state_q)
      StIdle: begin
        if (enable_i) begin
          // The entry edge is the first RUN sample: it carries ts=0 and always records.
          state_d     = StRun;
          ts_d        = TS_W'(1);
          ovf_d       = 1'b0;
          pend_d      = 1'b1;
          pend_ts_d   = '0;
          pend_data_d = fields_i;
        end
      end
      StRun: begin
        if (!enable_i) begin
          state_d = StIdle;
        end else if (ovf_event) begin
          state_d = StHalt;
          ovf_d   = 1'b1;
        end else begin
          ts_d = ts_q + TS_W'(1);
          // ts_q is zero inside RUN only after a wrap.
          if ((fields_i != prev_q) || wstb_i || (ts_q == '0)) begin
            pend_d      = 1'b1;
            pend_ts_d   = ts_q;
            pend_data_d = fields_i;
          end
        end
      end
      StHalt: begin
        if (!enable_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    active_d = (state_d == StRun);
    wr_ptr_d = push ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= StIdle;
      ts_q        <= '0;
      prev_q      <= '0;
      pend_q      <= 1'b0;
      pend_ts_q   <= '0;
      pend_data_q <= '0;
      ovf_q       <= 1'b0;
      active_q    <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
    end else begin
      state_q     <= state_d;
      ts_q        <= ts_d;
      prev_q      <= prev_d;
      pend_q      <= pend_d;
      pend_ts_q   <= pend_ts_d;
      pend_data_q <= pend_data_d;
      ovf_q       <= ovf_d;
      active_q    <= active_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
    end
  end

  // Storage is not reset; the pointers define what is valid.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_ts[wr_ptr_q[AW-1:0]]   <= pend_ts_q;
      mem_data[wr_ptr_q[AW-1:0]] <= pend_data_q;
    end
  end

  // Outputs are forced to zero when empty so they read 0 straight out of reset.
  assign rec_valid_o = !empty;
  assign rec_ts_o    = empty ? '0 : mem_ts[rd_ptr_q[AW-1:0]];
  assign rec_data_o  = empty ? '0 : mem_data[rd_ptr_q[AW-1:0]];
  assign overflow_o  = ovf_q;
  assign active_o    = active_q;

endmodule

// File: tb/tb_timing_capture_writer.sv
module tb_timing_capture_writer;

  logic        clk = 1'b0;
  logic        reset_i;
  logic        enable_i;
  logic [31:0] fields_i;
  logic        wstb_i;
  logic        rec_valid_o;
  logic        rec_ready_i;
  logic [31:0] rec_ts_o;
  logic [31:0] rec_data_o;
  logic        overflow_o;
  logic        active_o;

  int errors = 0;
  int checks = 0;

  logic [31:0] q_ts[$];
  logic [31:0] q_data[$];

  timing_capture_writer #(
    .DATA_W(32),
    .TS_W(32),
    .FIFO_DEPTH(16)
  ) dut (
    .clk_i      (clk),
    .reset_i    (reset_i),
    .enable_i   (enable_i),
    .fields_i   (fields_i),
    .wstb_i     (wstb_i),
    .rec_valid_o(rec_valid_o),
    .rec_ready_i(rec_ready_i),
    .rec_ts_o   (rec_ts_o),
    .rec_data_o (rec_data_o),
    .overflow_o (overflow_o),
    .active_o   (active_o)
  );

  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Log the record that the coming edge will pop.
  task automatic log_pop();
    if (rec_valid_o && rec_ready_i) begin
      q_ts.push_back(rec_ts_o);
      q_data.push_back(rec_data_o);
    end
  endtask

  task automatic do_reset();
    reset_i     = 1'b1;
    enable_i    = 1'b0;
    fields_i    = '0;
    wstb_i      = 1'b0;
    rec_ready_i = 1'b0;
    step();
    step();
    reset_i = 1'b0;
    q_ts.delete();
    q_data.delete();
  endtask

  task automatic test_reset();
    do_reset();
    checks += 5;
    if (rec_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", rec_valid_o); end
    if (rec_ts_o !== 32'h0) begin errors++; $display("FAIL reset_ts got=%h exp=0", rec_ts_o); end
    if (rec_data_o !== 32'h0) begin errors++; $display("FAIL reset_data got=%h exp=0", rec_data_o); end
    if (overflow_o !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", overflow_o); end
    if (active_o !== 1'b0) begin errors++; $display("FAIL reset_active got=%b exp=0", active_o); end
  endtask

  task automatic test_first_record();
    do_reset();
    enable_i = 1'b1;
    fields_i = 32'h5;
    step();
    checks += 2;
    if (rec_valid_o !== 1'b0) begin errors++; $display("FAIL first_valid_e1 got=%b exp=0", rec_valid_o); end
    if (active_o !== 1'b1) begin errors++; $display("FAIL first_active got=%b exp=1", active_o); end
    step();
    checks += 3;
    if (rec_valid_o !== 1'b1) begin errors++; $display("FAIL first_valid_e2 got=%b exp=1", rec_valid_o); end
    if (rec_ts_o !== 32'h0) begin errors++; $display("FAIL first_ts got=%h exp=0", rec_ts_o); end
    if (rec_data_o !== 32'h5) begin errors++; $display("FAIL first_data got=%h exp=5", rec_data_o); end
    rec_ready_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      log_pop();
      step();
    end
    checks += 2;
    if (q_ts.size() != 1) begin errors++; $display("FAIL first_count got=%0d exp=1", q_ts.size()); end
    if (rec_valid_o !== 1'b0) begin errors++; $display("FAIL first_drained got=%b exp=0", rec_valid_o); end
  endtask

  task automatic test_changes();
    logic [31:0] exp_ts[3];
    logic [31:0] exp_d[3];
    exp_ts = '{32'd0, 32'd3, 32'd7};
    exp_d  = '{32'h5, 32'h6, 32'h7};
    do_reset();
    enable_i    = 1'b1;
    rec_ready_i = 1'b1;
    for (int i = 0; i < 14; i++) begin
      fields_i = (i < 3) ? 32'h5 : (i < 7) ? 32'h6 : 32'h7;
      log_pop();
      step();
    end
    checks++;
    if (q_ts.size() != 3) begin errors++; $display("FAIL chg_count got=%0d exp=3", q_ts.size()); end
    for (int j = 0; j < 3 && j < q_ts.size(); j++) begin
      checks++;
      if (q_ts[j] !== exp_ts[j] || q_data[j] !== exp_d[j]) begin
        errors++;
        $display("FAIL chg_rec%0d got=(%0d,%h) exp=(%0d,%h)", j, q_ts[j], q_data[j], exp_ts[j], exp_d[j]);
      end
    end
  endtask

  task automatic test_wstb();
    logic [31:0] exp_ts[3];
    logic [31:0] exp_d[3];
    exp_ts = '{32'd0, 32'd4, 32'd6};
    exp_d  = '{32'h9, 32'h9, 32'hA};
    do_reset();
    enable_i    = 1'b1;
    rec_ready_i = 1'b1;
    for (int i = 0; i < 12; i++) begin
      fields_i = (i < 6) ? 32'h9 : 32'hA;
      wstb_i   = (i == 4) || (i == 6);
      log_pop();
      step();
    end
    wstb_i = 1'b0;
    checks++;
    if (q_ts.size() != 3) begin errors++; $display("FAIL wstb_count got=%0d exp=3", q_ts.size()); end
    for (int j = 0; j < 3 && j < q_ts.size(); j++) begin
      checks++;
      if (q_ts[j] !== exp_ts[j] || q_data[j] !== exp_d[j]) begin
        errors++;
        $display("FAIL wstb_rec%0d got=(%0d,%h) exp=(%0d,%h)", j, q_ts[j], q_data[j], exp_ts[j], exp_d[j]);
      end
    end
  endtask

  task automatic test_overflow();
    do_reset();
    enable_i = 1'b1;
    // Sample i carries ts=i; the 17th push arrives at edge 18 with the FIFO full.
    for (int i = 0; i < 17; i++) begin
      fields_i = i[0] ? 32'h1 : 32'h2;
      step();
    end
    checks += 2;
    if (overflow_o !== 1'b0) begin errors++; $display("FAIL ovf_before got=%b exp=0", overflow_o); end
    if (active_o !== 1'b1) begin errors++; $display("FAIL ovf_active_before got=%b exp=1", active_o); end
    fields_i = 32'h1;
    step();
    checks += 2;
    if (overflow_o !== 1'b1) begin errors++; $display("FAIL ovf_set got=%b exp=1", overflow_o); end
    if (active_o !== 1'b0) begin errors++; $display("FAIL ovf_active got=%b exp=0", active_o); end
    for (int i = 0; i < 4; i++) begin
      fields_i = i[0] ? 32'h1 : 32'h2;
      step();
    end
    rec_ready_i = 1'b1;
    for (int i = 0; i < 24; i++) begin
      log_pop();
      step();
    end
    checks += 3;
    if (q_ts.size() != 16) begin errors++; $display("FAIL ovf_drain_count got=%0d exp=16", q_ts.size()); end
    if (rec_valid_o !== 1'b0) begin errors++; $display("FAIL ovf_drain_valid got=%b exp=0", rec_valid_o); end
    if (overflow_o !== 1'b1) begin errors++; $display("FAIL ovf_sticky got=%b exp=1", overflow_o); end
    for (int j = 0; j < 16 && j < q_ts.size(); j++) begin
      checks++;
      if (q_ts[j] !== 32'(j) || q_data[j] !== ((j % 2) ? 32'h1 : 32'h2)) begin
        errors++;
        $display("FAIL ovf_rec%0d got=(%0d,%h) exp=(%0d,%h)", j, q_ts[j], q_data[j], j,
                 (j % 2) ? 32'h1 : 32'h2);
      end
    end
    enable_i = 1'b0;
    step();
    enable_i = 1'b1;
    step();
    checks++;
    if (overflow_o !== 1'b0) begin errors++; $display("FAIL ovf_clear got=%b exp=0", overflow_o); end
  endtask

  task automatic test_full_push_pop();
    do_reset();
    enable_i = 1'b1;
    for (int i = 0; i < 17; i++) begin
      fields_i = i[0] ? 32'h1 : 32'h2;
      step();
    end
    // FIFO full with ts16 pending: pop and push share edge 18. Hold fields so nothing new follows.
    rec_ready_i = 1'b1;
    fields_i    = 32'h2;
    log_pop();
    step();
    checks += 2;
    if (overflow_o !== 1'b0) begin errors++; $display("FAIL fpp_ovf got=%b exp=0", overflow_o); end
    if (active_o !== 1'b1) begin errors++; $display("FAIL fpp_active got=%b exp=1", active_o); end
    q_ts.delete();
    q_data.delete();
    enable_i = 1'b0;
    for (int i = 0; i < 24; i++) begin
      log_pop();
      step();
    end
    checks += 3;
    if (q_ts.size() != 16) begin errors++; $display("FAIL fpp_count got=%0d exp=16", q_ts.size()); end
    if (q_ts.size() > 0 && q_ts[0] !== 32'd1) begin
      errors++; $display("FAIL fpp_first_ts got=%0d exp=1", q_ts[0]);
    end
    if (q_ts.size() > 15 && q_ts[15] !== 32'd16) begin
      errors++; $display("FAIL fpp_last_ts got=%0d exp=16", q_ts[15]);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    enable_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      fields_i = (i < 5) ? (i[0] ? 32'hC1 : 32'hC2) : 32'hC2;
      step();
    end
    checks++;
    if (rec_valid_o !== 1'b1) begin errors++; $display("FAIL mid_valid_pre got=%b exp=1", rec_valid_o); end
    #2;
    reset_i = 1'b1;
    #1;
    checks += 5;
    if (rec_valid_o !== 1'b0) begin errors++; $display("FAIL mid_valid got=%b exp=0", rec_valid_o); end
    if (rec_ts_o !== 32'h0) begin errors++; $display("FAIL mid_ts got=%h exp=0", rec_ts_o); end
    if (rec_data_o !== 32'h0) begin errors++; $display("FAIL mid_data got=%h exp=0", rec_data_o); end
    if (overflow_o !== 1'b0) begin errors++; $display("FAIL mid_ovf got=%b exp=0", overflow_o); end
    if (active_o !== 1'b0) begin errors++; $display("FAIL mid_active got=%b exp=0", active_o); end
    step();
    reset_i     = 1'b0;
    fields_i    = 32'h33;
    rec_ready_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      log_pop();
      step();
    end
    checks += 2;
    if (q_ts.size() != 1) begin errors++; $display("FAIL mid_count got=%0d exp=1", q_ts.size()); end
    if (q_ts.size() > 0 && (q_ts[0] !== 32'd0 || q_data[0] !== 32'h33)) begin
      errors++; $display("FAIL mid_first got=(%0d,%h) exp=(0,33)", q_ts[0], q_data[0]);
    end
  endtask

  initial begin
    test_reset();
    test_first_record();
    test_changes();
    test_wstb();
    test_overflow();
    test_full_push_pop();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
